pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//   Parametrised, pipelined integer adder/subtractor for the RISC-V datapath (ALU ADD/SUB/SLT paths).
//   Splits a WIDTH-bit carry chain into STAGES equal chunks, one chunk resolved per pipeline stage.
//   Valid/ready handshake on both sides, full-pipeline stall on backpressure; results in order.
//   Produces sum, carry-out and signed overflow.
// PARAMETERS
//   WIDTH   32  operand/result width in bits
//   STAGES  4   pipeline stages = latency in cycles; WIDTH % STAGES == 0 required (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow: (A[MSB]==B'[MSB]) && (sum_raw[MSB]!=A[MSB]), B' = b or ~b
// BEHAVIOUR
//   - Clock/reset: one clock, clk; rst synchronous active-high, sampled on rising edge.
//   - CHUNK = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of a and B' with the
//     carry registered by stage k-1 (stage 0 carry-in = sub). Unresolved operand chunks and resolved
//     sum chunks travel with their entry through per-stage registers (skewed pipeline).
//   - Per stage: valid bit v[k]. advance = !v[STAGES-1] || out_ready. in_ready = advance.
//   - When advance=1 all stages shift one step; v[0] <= in_valid. When advance=0 all stage regs hold.
//   - Accept = in_valid && in_ready. Latency: accepted entry appears with out_valid=1 exactly STAGES
//     cycles after the accepting edge if no stall; each stall cycle adds one cycle.
//   - Throughput: one op per cycle while out_ready=1. Results leave in acceptance order, none dropped
//     or duplicated.
//   - out_valid = v[STAGES-1]; sum/cout/ovf driven from last-stage registers, stable while
//     out_valid && !out_ready.
//   - Bubbles (in_valid=0) propagate as invalid slots; they do not stall.
//   - Reset: all v[k] <= 0, all data regs <= 0 → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 the
//     cycle after rst. Reset mid-operation discards all in-flight entries; nothing emitted after.
//   - rst has priority over a simultaneous accept: an operand presented in a reset cycle is dropped.
//   - Wrap-around: sum is modulo 2^WIDTH; carry beyond MSB only visible on cout.
//   - in_ready is combinational from out_ready (documented path); no combinational a/b → sum path.
// CONFIGURATION
//   PIPE_ADDSUB_SAT_EN defined: when ovf=1, sum is clamped to signed saturation: 0x7FF..F if A[MSB]=0,
//     0x800..0 if A[MSB]=1. Clamp is in the output logic after the last stage; latency, handshake,
//     cout and ovf unchanged.
//   PIPE_ADDSUB_SAT_EN undefined: sum is always the raw modulo-2^WIDTH result.
// TESTING (WIDTH=32, STAGES=4)
//   1. a=0x0000_00FF, b=0x1, sub=0, out_ready=1 -> sum=0x0000_0100, cout=0, ovf=0, out_valid 4 cycles after accept.
//   2. a=0xFFFF_FFFF, b=0x1, sub=0 -> sum=0x0000_0000, cout=1, ovf=0 (carry crosses every chunk).
//   3. a=0x7FFF_FFFF, b=0x1, sub=0 -> ovf=1; sum=0x8000_0000 (SAT_EN off), 0x7FFF_FFFF (SAT_EN on).
//   4. a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=0x8000_0000, b=1, sub=1 -> ovf=1.
//   5. 8 back-to-back ops a=i, b=i (i=0..7), out_ready=0 in cycles 3-5 -> in_ready=0 while last stage
//      valid and stalled; outputs 0,2,..,14 in order, held stable during stall, none lost.
//   6. Accept 3 ops, assert rst for 1 cycle before any emerges -> out_valid=0 from next cycle,
//      no stale result ever emitted; next op after reset returns with normal 4-cycle latency.

Source files
------------

// File: rtl/pipe_addsub.sv
// ---------------------------------------------------------------------------
// pipe_addsub
//   Pipelined integer adder/subtractor for the ALU ADD/SUB/SLT paths.
//   The WIDTH-bit carry chain is cut into STAGES equal chunks; stage k
//   resolves chunk k using the carry registered by stage k-1 (stage 0 takes
//   `sub` as carry-in). Unresolved operand chunks and already-resolved sum
//   chunks travel alongside each entry (skewed pipeline). The whole pipeline
//   advances together and freezes on backpressure, so results stay in order.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  number of pipeline stages = latency in cycles
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   a, b       operands
//   sub        0: a+b, 1: a-b (computed as a + ~b + 1)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result (modulo 2^WIDTH, or saturated, see below)
//   cout       carry out of MSB (for subtraction, 1 = no borrow)
//   ovf        signed overflow
//
// Configuration
//   PIPE_ADDSUB_SAT_EN  when defined, sum is clamped to the signed limit on
//                       overflow (0x7FF..F if a was non-negative, 0x800..0
//                       otherwise). Latency, handshake, cout and ovf are
//                       unaffected. When undefined, sum is the raw result.
// ---------------------------------------------------------------------------
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;

    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    // Per-stage registers; index k holds the state leaving stage k.
    // b_q carries the already-conditioned operand B' (b or ~b).
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    logic             v_d [STAGES];
    logic             c_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];

    logic advance;

    // Only the last-stage valid can block: an empty output slot or a taking
    // consumer lets every stage shift at once.
    assign advance  = !v_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic             src_v;
        logic [CHUNK:0]   part;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        src_a = '0;
        src_b = '0;
        src_s = '0;
        src_c = 1'b0;
        src_v = 1'b0;
        part  = '0;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = 1'b0;
            c_d[k] = 1'b0;
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a = a;
                src_b = sub ? ~b : b;
                src_s = '0;
                src_c = sub;
                src_v = in_valid;
            end else begin
                src_a = a_q[k-1];
                src_b = b_q[k-1];
                src_s = s_q[k-1];
                src_c = c_q[k-1];
                src_v = v_q[k-1];
            end
            part = {1'b0, src_a[k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c};
            v_d[k] = src_v;
            c_d[k] = part[CHUNK];
            a_d[k] = src_a;
            b_d[k] = src_b;
            s_d[k] = src_s;
            s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        end
    end

    // NOTE: the datapath registers are reset along with the valids because
    // sum/cout/ovf must read zero right after reset, not just be ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            // NOTE: state is updated with non-blocking assignments so every
            // stage reads its predecessor's old value, giving a true shift.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    // Operands of equal sign whose result flips sign have overflowed.
    assign ovf       = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                       (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);

`ifdef PIPE_ADDSUB_SAT_EN
    always_comb begin
        sum = s_q[STAGES-1];
        if (ovf) begin
            sum = a_q[STAGES-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = s_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_addsub
//   Directed bench for pipe_addsub (WIDTH=32, STAGES=4). Inputs change 1 ns
//   after the rising edge; outputs are sampled there too, away from the edge.
//   Cycle numbering: cycle 1 is the cycle right after the accepting edge, so
//   a 4-stage pipe shows out_valid in cycle 4.
// ---------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Directed vectors with hand-computed results.
    localparam int NVEC = 8;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [31:0] SUM2 = 32'h7FFF_FFFF;
    localparam logic [31:0] SUM4 = 32'h8000_0000;
    localparam logic [31:0] SUM6 = 32'h8000_0000;
`else
    localparam logic [31:0] SUM2 = 32'h8000_0000;
    localparam logic [31:0] SUM4 = 32'h7FFF_FFFF;
    localparam logic [31:0] SUM6 = 32'h0000_0000;
`endif
    logic [31:0] vec_a   [NVEC] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005,
                                    32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 32'h0000_1234};
    logic [31:0] vec_b   [NVEC] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                                    32'h0000_0001, 32'h9ABC_DEF0, 32'h8000_0000, 32'h0000_1234};
    logic        vec_sub [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] vec_sum [NVEC] = '{32'h0000_0100, 32'h0000_0000, SUM2, 32'hFFFF_FFFE,
                                    SUM4, 32'hACF1_3568, SUM6, 32'h0000_0000};
    logic        vec_co  [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        vec_ov  [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one op into an idle pipe and waits (bounded) for its result.
    // lat is the cycle number (1 = right after accept) where out_valid rose.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic osub,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output int lat);
        in_valid  = 1'b1;
        a         = oa;
        b         = ob;
        sub       = osub;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum;
        rc = cout;
        ro = ovf;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h0000_0011;
        b         = 32'h0000_0022;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        // The operand presented during reset must never come out.
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drop cyc=%0d out_valid got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        for (int i = 0; i < NVEC; i++) begin
            do_op(vec_a[i], vec_b[i], vec_sub[i], rs, rc, ro, lat);
            checks++; if (lat !== STAGES) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, STAGES); end
            checks++; if (rs !== vec_sum[i]) begin errors++; $display("FAIL vec%0d_sum got=%h exp=%h", i, rs, vec_sum[i]); end
            checks++; if (rc !== vec_co[i]) begin errors++; $display("FAIL vec%0d_cout got=%b exp=%b", i, rc, vec_co[i]); end
            checks++; if (ro !== vec_ov[i]) begin errors++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, ro, vec_ov[i]); end
        end
    endtask

    // Eight ops a=b=i, consumer stalls in cycles 3..5. Ops are accepted at
    // edges 0,1,2,3,6,7,8,9, so results are valid in cycles 4..13 and the
    // input side is blocked in cycles 4 and 5.
    task automatic test_back_to_back();
        int  sent = 0;
        int  recv = 0;
        logic exp_ready;
        logic exp_valid;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            a         = sent;
            b         = sent;
            sub       = 1'b0;
            #1;
            exp_ready = !(c == 4 || c == 5);
            exp_valid = (c >= 4 && c <= 13);
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready); end
            checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_valid); end
            if (out_valid) begin
                checks++; if (sum !== 32'(2 * recv)) begin errors++; $display("FAIL b2b_sum cyc=%0d got=%0d exp=%0d", c, sum, 2 * recv); end
                checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL b2b_flags cyc=%0d got=%b exp=00", c, {cout, ovf}); end
                if (out_ready) recv++;
            end
            if (in_valid && exp_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 8) begin errors++; $display("FAIL b2b_received got=%0d exp=8", recv); end
    endtask

    // Three ops in flight, then a one-cycle reset: nothing may emerge, and a
    // fresh op afterwards behaves normally.
    task automatic test_reset_flush();
        logic [31:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        out_ready = 1'b1;
        sub       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 32'(i + 10);
            b        = 32'h1;
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'd99;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
            tick();
        end
        do_op(32'd3, 32'd4, 1'b0, rs, rc, ro, lat);
        checks++; if (lat !== STAGES) begin errors++; $display("FAIL flush_latency got=%0d exp=%0d", lat, STAGES); end
        checks++; if (rs !== 32'd7) begin errors++; $display("FAIL flush_sum got=%h exp=00000007", rs); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
